diff_decode_pipe_stage: RTL and testbench

DIFF_DECODE_PIPE_STAGE -- requirements
Module: diff_decode_pipe_stage

---
 rtl/diff_decode_pipe_stage.sv | 153 +++++++++++++++
 tb/tb_diff_decode_pipe_stage.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/diff_decode_pipe_stage.sv
// Pipeline register stage between the diff and decode stages with valid/ready handshake.
// Define DIFF_DECODE_SKID_EN for a two-entry skid buffer with registered in_ready.
module diff_decode_pipe_stage #(
  parameter int unsigned size        = 3,
  parameter int unsigned data_size   = 16,
  parameter int unsigned index_width = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [data_size*size-1:0]   predict_value,
  input  logic [data_size*size-1:0]   z,
  input  logic [data_size*size-1:0]   dc_dw,
  input  logic [index_width-1:0]      w_layer_index,
  input  logic [index_width-1:0]      w_row_index,
  input  logic                        update_weight,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [data_size*size-1:0]   predict_value_out,
  output logic [data_size*size-1:0]   z_out,
  output logic [data_size*size-1:0]   dc_dw_out,
  output logic [index_width-1:0]      w_layer_index_out,
  output logic [index_width-1:0]      w_row_index_out,
  output logic                        update_weight_out,
  output logic [1:0]                  occupancy
);

  localparam int unsigned vec_w    = data_size * size;
  localparam int unsigned bundle_w = 3 * vec_w + 2 * index_width + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t              state;
  logic                out_valid_q;
  logic [bundle_w-1:0] in_bundle;
  logic [bundle_w-1:0] main_q;
  logic                do_accept;
  logic                do_release;

  // All payload fields travel as one bundle.
  assign in_bundle = {predict_value, z, dc_dw, w_layer_index, w_row_index, update_weight};
  assign {predict_value_out, z_out, dc_dw_out,
          w_layer_index_out, w_row_index_out, update_weight_out} = main_q;

  assign out_valid  = out_valid_q;
  assign occupancy  = state;
  assign do_accept  = in_valid && in_ready;
  assign do_release = out_valid_q && out_ready;

`ifdef DIFF_DECODE_SKID_EN

  logic [bundle_w-1:0] skid_q;
  logic                in_ready_q;

  // Registered ready; masked only while reset is held so nothing is offered during reset.
  assign in_ready = in_ready_q && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (do_accept) begin
            main_q      <= in_bundle;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (do_accept && do_release) begin
            main_q <= in_bundle;
          end else if (do_accept) begin
            skid_q     <= in_bundle;
            in_ready_q <= 1'b0;
            state      <= TWO;
          end else if (do_release) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a release can happen.
          if (do_release) begin
            main_q     <= skid_q;
            in_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`else

  // Single entry: a held bundle can be replaced on the edge it is released.
  assign in_ready = !reset && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      main_q      <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (do_accept) begin
            main_q      <= in_bundle;
            out_valid_q <= 1'b1;
            state       <= ONE;
          end
        end
        ONE: begin
          if (do_accept) begin
            main_q <= in_bundle;
          end else if (do_release) begin
            out_valid_q <= 1'b0;
            state       <= EMPTY;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_diff_decode_pipe_stage.sv
// Directed self-checking bench for diff_decode_pipe_stage (either buffering build).
module tb_diff_decode_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] predict_value, z, dc_dw;
  logic [31:0] w_layer_index, w_row_index;
  logic        update_weight;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] predict_value_out, z_out, dc_dw_out;
  logic [31:0] w_layer_index_out, w_row_index_out;
  logic        update_weight_out;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DIFF_DECODE_SKID_EN
  localparam int unsigned cap = 2;
`else
  localparam int unsigned cap = 1;
`endif

  diff_decode_pipe_stage dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .predict_value     (predict_value),
    .z                 (z),
    .dc_dw             (dc_dw),
    .w_layer_index     (w_layer_index),
    .w_row_index       (w_row_index),
    .update_weight     (update_weight),
    .flush             (flush),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .predict_value_out (predict_value_out),
    .z_out             (z_out),
    .dc_dw_out         (dc_dw_out),
    .w_layer_index_out (w_layer_index_out),
    .w_row_index_out   (w_row_index_out),
    .update_weight_out (update_weight_out),
    .occupancy         (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bundle fields are all derived from a row tag so any field mix-up is visible.
  task automatic set_bundle(input int row);
    predict_value = {3{16'(row)}};
    z             = 48'(row) ^ 48'hFFFF;
    dc_dw         = 48'(row * 7);
    w_layer_index = 32'(row + 1);
    w_row_index   = 32'(row);
    update_weight = row[0];
  endtask

  task automatic check_bundle(input string tag, input int row);
    check({tag, "_pv"},  64'(predict_value_out), 64'({3{16'(row)}}));
    check({tag, "_z"},   64'(z_out),             64'(48'(row) ^ 48'hFFFF));
    check({tag, "_row"}, 64'(w_row_index_out),   64'(row));
    check({tag, "_upd"}, 64'(update_weight_out), 64'(row & 1));
  endtask

  // Push 'count' bundles starting at row 'first' with out_ready held low.
  task automatic fill(input int first, input int count);
    out_ready = 1'b0;
    for (int i = 0; i < count; i++) begin
      set_bundle(first + i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_bundle(0);

    // Reset state
    tick(); tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_pv", 64'(predict_value_out), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Single transfer
    predict_value = 48'h0003_0002_0001;
    w_layer_index = 32'd2;
    update_weight = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_pv", 64'(predict_value_out), 64'h0003_0002_0001);
    check("single_layer", 64'(w_layer_index_out), 64'd2);
    check("single_upd", 64'(update_weight_out), 64'd1);
    check("single_occ", 64'(occupancy), 64'd1);
    tick();
    check("single_drain_valid", 64'(out_valid), 64'd0);
    check("single_drain_occ", 64'(occupancy), 64'd0);

`ifdef DIFF_DECODE_SKID_EN
    // Back-pressure into the skid entry
    fill(10, 1);
    check("bp_occ1", 64'(occupancy), 64'd1);
    check("bp_ready1", 64'(in_ready), 64'd1);
    set_bundle(11); in_valid = 1'b1;
    tick();
    // Offer C while full; it must not be taken
    set_bundle(12);
    check("bp_occ2", 64'(occupancy), 64'd2);
    check("bp_ready2", 64'(in_ready), 64'd0);
    check_bundle("bp_hold_a", 10);
    tick();
    in_valid = 1'b0;
    check("bp_occ2_hold", 64'(occupancy), 64'd2);
    check_bundle("bp_hold_a2", 10);
    out_ready = 1'b1;
    tick();
    check_bundle("bp_b", 11);
    check("bp_b_occ", 64'(occupancy), 64'd1);
    check("bp_b_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_empty_valid", 64'(out_valid), 64'd0);
    check("bp_empty_occ", 64'(occupancy), 64'd0);
`else
    // Single-entry back-pressure and same-edge replace
    fill(10, 1);
    check("ns_occ1", 64'(occupancy), 64'd1);
    check("ns_ready_blocked", 64'(in_ready), 64'd0);
    tick();
    check_bundle("ns_hold_a", 10);
    set_bundle(11); in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("ns_ready_pass", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("ns_replace_occ", 64'(occupancy), 64'd1);
    check_bundle("ns_replace_b", 11);
    tick();
    check_bundle("ns_hold_b", 11);
    out_ready = 1'b1;
    tick();
    check("ns_empty_valid", 64'(out_valid), 64'd0);
    check("ns_empty_occ", 64'(occupancy), 64'd0);
`endif

    // Streaming at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_bundle(i);
      in_valid = 1'b1;
      #1;
      check("stream_ready", 64'(in_ready), 64'd1);
      tick();
      check("stream_valid", 64'(out_valid), 64'd1);
      check("stream_row", 64'(w_row_index_out), 64'(i));
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", 64'(out_valid), 64'd0);

    // Flush with a concurrent accept and release
    fill(200, int'(cap));
    check("fl_full_occ", 64'(occupancy), 64'(cap));
    set_bundle(300); in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    tick(); tick();
    check("fl_stays_empty", 64'(out_valid), 64'd0);
    set_bundle(301); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_bundle("fl_next", 301);
    tick();
    check("fl_next_drain", 64'(out_valid), 64'd0);

    // Reset mid-operation
    fill(51, 1);
    check("mr_occ", 64'(occupancy), 64'd1);
    reset = 1'b1;
    #1;
    check("mr_ready_during", 64'(in_ready), 64'd0);
    tick();
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_occ0", 64'(occupancy), 64'd0);
    check("mr_pv", 64'(predict_value_out), 64'd0);
    check("mr_row", 64'(w_row_index_out), 64'd0);
    check("mr_upd", 64'(update_weight_out), 64'd0);
    check("mr_ready_held", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    check("mr_ready_after", 64'(in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
